// File: rtl/handshake_pkg.sv
// Purpose : shared types and constants for the handshake TX buffer and its clock-crossing stage.
// Latency : n/a (package only).
// Backpress: n/a (package only).
package handshake_pkg;

    // TX handshake FSM. The crossing stage drops its ready while a transfer
    // is in flight, so each transfer is one SEND pulse followed by a full
    // fall-then-rise cycle on the ready line.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DROP = 2'd2,
        ST_WAIT_RISE = 2'd3
    } tx_state_e;

    // Crossing stage: flops used to resynchronise the request and acknowledge
    // in each clock domain.
    localparam int unsigned CDC_SYNC_STAGES = 2;

    // Width of the completed-transfer counter. It wraps modulo 2**SENT_CNT_W.
    localparam int unsigned SENT_CNT_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Purpose : single-clock show-ahead FIFO with a separate level counter and registered ready.
// Latency : a pushed word is visible on rd_dat_o the cycle after the push edge.
// Backpress: wr_rdy_o is registered (level != DEPTH); a pop frees space one cycle later, with no same-cycle fall-through.
//
// Ports:
//   clk_i, srst_i          clock and synchronous active-high reset
//   wr_vld_i/wr_dat_i      write request and data, accepted when wr_rdy_o is high
//   wr_rdy_o               registered not-full flag
//   rd_pop_i               advance the head; ignored while empty
//   rd_dat_o               head word, don't-care while empty
//   level_o                number of stored words, 0..DEPTH
module sync_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     wr_vld_i,
    input  logic [DATA_W-1:0]        wr_dat_i,
    output logic                     wr_rdy_o,
    input  logic                     rd_pop_i,
    output logic [DATA_W-1:0]        rd_dat_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              wr_rdy_q, wr_rdy_d;
    logic              push, pop;

    assign push = wr_vld_i & wr_rdy_q;
    assign pop  = rd_pop_i & (level_q != '0);

    // Pointers are exactly AW bits, so DEPTH being a power of two makes the
    // natural overflow the modulo-DEPTH wrap. Fullness comes from the level
    // counter, not from pointer comparison.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Ready is registered from the next level, so it is valid from the
        // first cycle after any push or pop without a combinational path.
        wr_rdy_d = (level_d != LW'(DEPTH));
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            wr_rdy_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            wr_rdy_q <= wr_rdy_d;
        end
    end

    // Storage has no reset; the pointers and level define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign wr_rdy_o = wr_rdy_q;
    assign level_o  = level_q;

endmodule

// File: rtl/handshake_tx_fifo.sv
// Purpose : buffers upstream words and hands them one at a time to a clock-crossing stage.
// Latency : a word pushed into an idle, empty buffer raises data_val_o in the cycle after the next edge.
// Backpress: upstream is stalled by registered data_ready_o (full); downstream paces transfers with its ready line.
//
// Ports:
//   clk_i, srst_i              clock and synchronous active-high reset
//   data_i/data_val_i          upstream write, accepted while data_ready_o is high
//   data_ready_o               buffer not full (registered)
//   data_o                     head word shown to the crossing stage, stable for the whole transfer
//   data_val_o                 one-cycle start-of-transfer pulse
//   data_ready_i               crossing-stage idle flag; low while a transfer is in flight
//   level_o                    stored words, including the one in flight
//   sent_cnt_o                 completed transfers, wrapping
module handshake_tx_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    data_val_i,
    output logic                    data_ready_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    data_val_o,
    input  logic                    data_ready_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [15:0]             sent_cnt_o
);

    tx_state_e             state_q, state_d;
    logic [SENT_CNT_W-1:0] sent_cnt_q, sent_cnt_d;
    logic                  pop;
    logic                  have_word;

    // The head word stays in the FIFO until the transfer completes, so
    // data_o is stable from SEND until the pop and level counts it as stored.
    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .wr_vld_i (data_val_i),
        .wr_dat_i (data_i),
        .wr_rdy_o (data_ready_o),
        .rd_pop_i (pop),
        .rd_dat_o (data_o),
        .level_o  (level_o)
    );

    assign have_word = (level_o != '0);

    always_comb begin
        state_d    = state_q;
        sent_cnt_d = sent_cnt_q;
        pop        = 1'b0;
        data_val_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (have_word && data_ready_i) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                data_val_o = 1'b1;
                state_d    = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                // The crossing stage must acknowledge by dropping ready;
                // until it does, nothing is released.
                if (!data_ready_i) begin
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                if (data_ready_i) begin
                    state_d    = ST_IDLE;
                    pop        = 1'b1;
                    sent_cnt_d = sent_cnt_q + SENT_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= ST_IDLE;
            sent_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign sent_cnt_o = sent_cnt_q;

endmodule

// File: tb/tb_handshake_tx_fifo.sv
module tb_handshake_tx_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk_i = 1'b0;
    logic              srst_i;
    logic [DATA_W-1:0] data_i;
    logic              data_val_i;
    logic              data_ready_o;
    logic [DATA_W-1:0] data_o;
    logic              data_val_o;
    logic              data_ready_i;
    logic [3:0]        level_o;
    logic [15:0]       sent_cnt_o;

    // Crossing-stage ready comes from either directed steps or the
    // auto-responder used for streaming.
    logic auto_mode = 1'b0;
    logic man_rdy   = 1'b1;
    logic resp_rdy  = 1'b1;
    assign data_ready_i = auto_mode ? resp_rdy : man_rdy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rx     = 0;
    logic [DATA_W-1:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    handshake_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .data_i       (data_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .data_o       (data_o),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i),
        .level_o      (level_o),
        .sent_cnt_o   (sent_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (on negedges) for a data_val_o pulse, bounded.
    task automatic wait_val(input string tag);
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (data_val_o) break;
        end
        chk(tag, 32'(data_val_o), 32'd1);
    endtask

    // One full directed transfer starting from IDLE; checks the head word.
    task automatic xfer_one(input logic [DATA_W-1:0] exp_word, input string tag);
        man_rdy = 1'b1;
        wait_val({tag, "_val"});
        chk({tag, "_dat"}, 32'(data_o), 32'(exp_word));
        man_rdy = 1'b0;
        @(negedge clk_i);
        chk({tag, "_pulse1"}, 32'(data_val_o), 32'd0);
        @(negedge clk_i);
        man_rdy = 1'b1;
        @(negedge clk_i);
        man_rdy = 1'b0;
    endtask

    // Crossing-stage model for streaming: take each pulse, compare against
    // the scoreboard, then stay busy for a random number of cycles.
    int hold = 0;
    always @(negedge clk_i) begin
        if (auto_mode) begin
            if (data_val_o) begin
                n_assert++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL stream_extra observed=pulse expected=none");
                end
                if (sb_q.size() != 0) begin
                    chk("stream_word", 32'(data_o), 32'(sb_q.pop_front()));
                end
                n_rx++;
                resp_rdy = 1'b0;
                hold     = $urandom_range(1, 4);
            end else if (!resp_rdy) begin
                if (hold == 0) resp_rdy = 1'b1;
                else hold--;
            end
        end
    end

    initial begin
        int  pushed;
        int  val_seen;
        srst_i     = 1'b1;
        data_i     = '0;
        data_val_i = 1'b0;
        man_rdy    = 1'b1;
        repeat (3) @(negedge clk_i);
        srst_i = 1'b0;
        @(negedge clk_i);

        // Reset state
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_val", 32'(data_val_o), 32'd0);
        chk("rst_rdy", 32'(data_ready_o), 32'd1);
        chk("rst_sent", 32'(sent_cnt_o), 32'd0);

        // Single transfer of 0xA5A5: pulse two edges after push
        data_i = 16'hA5A5; data_val_i = 1'b1;
        @(negedge clk_i);
        data_val_i = 1'b0;
        chk("a5_early_val", 32'(data_val_o), 32'd0);
        chk("a5_level1", 32'(level_o), 32'd1);
        @(negedge clk_i);
        chk("a5_val", 32'(data_val_o), 32'd1);
        chk("a5_dat", 32'(data_o), 32'hA5A5);
        @(negedge clk_i);
        chk("a5_pulse1", 32'(data_val_o), 32'd0);
        man_rdy = 1'b0;
        @(negedge clk_i);
        chk("a5_hold_dat", 32'(data_o), 32'hA5A5);
        chk("a5_hold_level", 32'(level_o), 32'd1);
        man_rdy = 1'b1;
        @(negedge clk_i);
        chk("a5_level0", 32'(level_o), 32'd0);
        chk("a5_sent", 32'(sent_cnt_o), 32'd1);

        // Fill with 0..7 while the crossing stage is busy, then a 9th push
        man_rdy  = 1'b0;
        val_seen = 0;
        for (int i = 0; i < 8; i++) begin
            data_i = 16'(i); data_val_i = 1'b1;
            @(negedge clk_i);
            if (data_val_o) val_seen++;
        end
        chk("full_rdy", 32'(data_ready_o), 32'd0);
        chk("full_level", 32'(level_o), 32'd8);
        data_i = 16'h0099;
        @(negedge clk_i);
        data_val_i = 1'b0;
        chk("full_ign_level", 32'(level_o), 32'd8);
        chk("full_no_val", 32'(val_seen), 32'd0);
        chk("full_head", 32'(data_o), 32'd0);

        // Ready never drops after SEND: stuck in WAIT_DROP, no pop
        man_rdy = 1'b1;
        wait_val("stuck_val");
        val_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (data_val_o) val_seen++;
        end
        chk("stuck_level", 32'(level_o), 32'd8);
        chk("stuck_no_val", 32'(val_seen), 32'd0);
        chk("stuck_sent", 32'(sent_cnt_o), 32'd1);
        man_rdy = 1'b0;
        @(negedge clk_i);
        man_rdy = 1'b1;
        @(negedge clk_i);
        man_rdy = 1'b0;
        // Pop from full: ready returns on the next cycle
        chk("unfull_level", 32'(level_o), 32'd7);
        chk("unfull_rdy", 32'(data_ready_o), 32'd1);
        chk("unfull_sent", 32'(sent_cnt_o), 32'd2);

        // Drain three more (heads 1,2,3) to reach level 4
        xfer_one(16'd1, "drain1");
        xfer_one(16'd2, "drain2");
        xfer_one(16'd3, "drain3");
        chk("lvl4", 32'(level_o), 32'd4);

        // Push and pop on the same edge at level 4
        man_rdy = 1'b1;
        wait_val("pp_val");
        chk("pp_head", 32'(data_o), 32'd4);
        man_rdy = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        man_rdy = 1'b1; data_i = 16'h1234; data_val_i = 1'b1;
        @(negedge clk_i);
        man_rdy = 1'b0; data_val_i = 1'b0;
        chk("pp_level", 32'(level_o), 32'd4);
        chk("pp_next", 32'(data_o), 32'd5);

        // Reset during WAIT_RISE with 3 words stored
        xfer_one(16'd5, "pre_rst");
        man_rdy = 1'b1;
        wait_val("mid_val");
        man_rdy = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("mid_level3", 32'(level_o), 32'd3);
        srst_i = 1'b1;
        @(negedge clk_i);
        srst_i = 1'b0;
        chk("mid_rst_level", 32'(level_o), 32'd0);
        chk("mid_rst_val", 32'(data_val_o), 32'd0);
        chk("mid_rst_rdy", 32'(data_ready_o), 32'd1);
        chk("mid_rst_sent", 32'(sent_cnt_o), 32'd0);
        @(negedge clk_i);

        // Stream 100 random words through the responder model
        resp_rdy  = 1'b1;
        auto_mode = 1'b1;
        pushed    = 0;
        while (pushed < 100) begin
            data_i     = 16'($urandom);
            data_val_i = ($urandom_range(0, 3) != 0);
            if (data_val_i && data_ready_o) begin
                sb_q.push_back(data_i);
                pushed++;
            end
            @(negedge clk_i);
        end
        data_val_i = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (sent_cnt_o == 16'd100) break;
            @(negedge clk_i);
        end
        chk("stream_sent", 32'(sent_cnt_o), 32'd100);
        chk("stream_rx", 32'(n_rx), 32'd100);
        chk("stream_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("stream_level", 32'(level_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
